// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes columns active-low, debounces rows, and
// emits one hex code per press plus a 4-digit shift register for the display.
//
// state  | meaning
// S_SCAN | column advances each tick until a row reads low
// S_DEB  | column frozen, counting consecutive matching ticks for the candidate
// S_HELD | key accepted, counting consecutive released ticks before rescanning
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] value
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [7:0] DB = 8'(DEBOUNCE);

  typedef enum logic [1:0] {S_SCAN, S_DEB, S_HELD} state_t;

  state_t        state, state_n;
  logic [3:0]    row_meta, rs;
  logic [DW-1:0] div;
  logic          tick;
  logic [1:0]    ci, ci_n;
  logic [3:0]    cand, cand_n;
  logic [7:0]    cnt, cnt_n;
  logic [7:0]    rel, rel_n;
  logic [3:0]    key_n;
  logic [15:0]   value_n;
  logic          valid_n, held_n;
  logic          pressed;
  logic [1:0]    ri;
  logic          accept;

  assign tick    = (div == DIV_LAST);
  assign pressed = (rs != 4'b1111);
  assign col     = ~(4'b0001 << ci);

  // Lower row index wins when several rows are low.
  always_comb begin
    ri = 2'd3;
    if (!rs[0])      ri = 2'd0;
    else if (!rs[1]) ri = 2'd1;
    else if (!rs[2]) ri = 2'd2;
  end

  always_comb begin
    state_n = state;
    ci_n    = ci;
    cand_n  = cand;
    cnt_n   = cnt;
    rel_n   = rel;
    key_n   = key;
    value_n = value;
    valid_n = 1'b0;
    held_n  = key_held;
    accept  = 1'b0;
    if (tick) begin
      case (state)
        S_SCAN: begin
          if (pressed) begin
            cand_n  = {ri, ci};
            cnt_n   = 8'd1;
            state_n = S_DEB;
            if (DB == 8'd1) accept = 1'b1;
          end else begin
            ci_n = ci + 2'd1;
          end
        end
        S_DEB: begin
          if (pressed && (ri == cand[3:2])) begin
            cnt_n = cnt + 8'd1;
            if (cnt + 8'd1 == DB) accept = 1'b1;
          end else begin
            state_n = S_SCAN;
            ci_n    = ci + 2'd1;
          end
        end
        S_HELD: begin
          if (!pressed) begin
            rel_n = rel + 8'd1;
            if (rel + 8'd1 == DB) begin
              held_n  = 1'b0;
              ci_n    = ci + 2'd1;
              state_n = S_SCAN;
            end
          end else begin
            rel_n = 8'd0;
          end
        end
        default: state_n = S_SCAN;
      endcase
    end
    // cand_n is used so a single-sample debounce accepts the code latched this tick.
    if (accept) begin
      key_n   = cand_n;
      value_n = {value[11:0], cand_n};
      valid_n = 1'b1;
      held_n  = 1'b1;
      rel_n   = 8'd0;
      state_n = S_HELD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_meta  <= 4'b1111;
      rs        <= 4'b1111;
      div       <= '0;
      state     <= S_SCAN;
      ci        <= 2'd0;
      cand      <= 4'd0;
      cnt       <= 8'd0;
      rel       <= 8'd0;
      key       <= 4'd0;
      value     <= 16'h0000;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      row_meta  <= row;
      rs        <= row_meta;
      div       <= tick ? '0 : div + DW'(1);
      state     <= state_n;
      ci        <= ci_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      rel       <= rel_n;
      key       <= key_n;
      value     <= value_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3 and a
// keypad model that pulls a row low when its key is pressed and its column strobed.
module tb_keypad_scanner;

  logic        clock;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] value;

  logic [15:0] keys;
  int n_cmp;
  int n_err;
  int pulses;
  int run_len;
  int max_run;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clock(clock), .reset(reset), .row(row), .col(col),
    .key(key), .key_valid(key_valid), .key_held(key_held), .value(value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && (col[c] == 1'b0)) row[r] = 1'b0;
  end

  always @(negedge clock) begin
    if (reset) begin
      run_len = 0;
    end else if (key_valid) begin
      pulses  = pulses + 1;
      run_len = run_len + 1;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (key_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_held_low(input int bound, output int n);
    n = bound + 1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clock);
      if (!key_held) begin n = i; break; end
    end
  endtask

  task automatic wait_col(input logic [3:0] c, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (col == c) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    keys = 16'h0000;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      n_cmp++;
      if (col !== exp_col) begin
        n_err++; $display("FAIL reset_col[%0d]: got %b expected %b", i, col, exp_col);
      end
      n_cmp++;
      if (key_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_valid[%0d]: got %b expected 0", i, key_valid);
      end
      @(negedge clock);
    end
    n_cmp++;
    if (value !== 16'h0000) begin n_err++; $display("FAIL reset_value: got %h expected 0000", value); end
    n_cmp++;
    if (key !== 4'h0) begin n_err++; $display("FAIL reset_key: got %h expected 0", key); end
    n_cmp++;
    if (key_held !== 1'b0) begin n_err++; $display("FAIL reset_held: got %b expected 0", key_held); end
  endtask

  task automatic test_single_key();
    bit ok;
    int p0, n;
    p0 = pulses;
    keys = 16'h0200;
    wait_valid(100, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL single_valid: got timeout expected pulse"); end
    n_cmp++;
    if (key !== 4'h9) begin n_err++; $display("FAIL single_key: got %h expected 9", key); end
    n_cmp++;
    if (value !== 16'h0009) begin n_err++; $display("FAIL single_value: got %h expected 0009", value); end
    n_cmp++;
    if (key_held !== 1'b1) begin n_err++; $display("FAIL single_held: got %b expected 1", key_held); end
    repeat (20) @(negedge clock);
    n_cmp++;
    if (pulses - p0 !== 1) begin n_err++; $display("FAIL single_pulses: got %0d expected 1", pulses - p0); end
    keys = 16'h0000;
    wait_held_low(30, n);
    n_cmp++;
    if (n < 11 || n > 14) begin n_err++; $display("FAIL single_release_cycles: got %0d expected 11..14", n); end
    n_cmp++;
    if (col !== 4'b1011) begin n_err++; $display("FAIL single_resume_col: got %b expected 1011", col); end
  endtask

  task automatic test_key_sequence();
    bit ok;
    int p0, n;
    p0 = pulses;
    for (int c = 1; c <= 5; c++) begin
      keys = 16'h0001 << c;
      wait_valid(100, ok);
      n_cmp++;
      if (ok !== 1'b1 || key !== 4'(c)) begin
        n_err++; $display("FAIL seq_key[%0d]: got %h (pulse %0d) expected %h", c, key, ok, 4'(c));
      end
      repeat (5) @(negedge clock);
      keys = 16'h0000;
      wait_held_low(40, n);
      n_cmp++;
      if (n > 40) begin n_err++; $display("FAIL seq_release[%0d]: got timeout expected key_held low", c); end
    end
    n_cmp++;
    if (pulses - p0 !== 5) begin n_err++; $display("FAIL seq_pulses: got %0d expected 5", pulses - p0); end
    n_cmp++;
    if (value !== 16'h2345) begin n_err++; $display("FAIL seq_value: got %h expected 2345", value); end
    n_cmp++;
    if (key !== 4'h5) begin n_err++; $display("FAIL seq_last_key: got %h expected 5", key); end
  endtask

  task automatic test_bounce();
    bit ok;
    int p0;
    p0 = pulses;
    wait_col(4'b0111, 40, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL bounce_wait_col: got %b expected 0111", col); end
    keys = 16'h0008;
    repeat (9) @(negedge clock);
    keys = 16'h0000;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (col !== 4'b0111) begin n_err++; $display("FAIL bounce_frozen_col: got %b expected 0111", col); end
    @(negedge clock);
    n_cmp++;
    if (col !== 4'b1110) begin n_err++; $display("FAIL bounce_resume_col: got %b expected 1110", col); end
    repeat (20) @(negedge clock);
    n_cmp++;
    if (pulses - p0 !== 0) begin n_err++; $display("FAIL bounce_pulses: got %0d expected 0", pulses - p0); end
    n_cmp++;
    if (value !== 16'h2345) begin n_err++; $display("FAIL bounce_value: got %h expected 2345", value); end
  endtask

  task automatic test_priority_hold();
    bit ok;
    int p0, n;
    p0 = pulses;
    keys = 16'h4040;
    wait_valid(100, ok);
    n_cmp++;
    if (ok !== 1'b1 || key !== 4'h6) begin
      n_err++; $display("FAIL prio_key: got %h (pulse %0d) expected 6", key, ok);
    end
    repeat (200) @(negedge clock);
    n_cmp++;
    if (pulses - p0 !== 1) begin n_err++; $display("FAIL prio_hold_pulses: got %0d expected 1", pulses - p0); end
    keys = keys | 16'h0004;
    repeat (100) @(negedge clock);
    n_cmp++;
    if (pulses - p0 !== 1) begin n_err++; $display("FAIL prio_second_key: got %0d pulses expected 1", pulses - p0); end
    n_cmp++;
    if (key !== 4'h6 || key_held !== 1'b1) begin
      n_err++; $display("FAIL prio_key_kept: got key %h held %b expected 6 / 1", key, key_held);
    end
    keys = 16'h0000;
    wait_held_low(40, n);
    n_cmp++;
    if (n > 40) begin n_err++; $display("FAIL prio_release: got timeout expected key_held low"); end
    n_cmp++;
    if (value !== 16'h3456) begin n_err++; $display("FAIL prio_value: got %h expected 3456", value); end
  endtask

  task automatic test_reset_mid_debounce();
    bit ok;
    int p0;
    wait_col(4'b1101, 40, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL rstdeb_wait_col: got %b expected 1101", col); end
    keys = 16'h0020;
    repeat (9) @(negedge clock);
    n_cmp++;
    if (col !== 4'b1101) begin n_err++; $display("FAIL rstdeb_frozen_col: got %b expected 1101", col); end
    reset = 1'b1;
    keys  = 16'h0000;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (col !== 4'b1110) begin n_err++; $display("FAIL rstdeb_col: got %b expected 1110", col); end
    n_cmp++;
    if (key !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      n_err++; $display("FAIL rstdeb_outputs: got key %h valid %b held %b expected 0/0/0", key, key_valid, key_held);
    end
    n_cmp++;
    if (value !== 16'h0000) begin n_err++; $display("FAIL rstdeb_value: got %h expected 0000", value); end
    p0 = pulses;
    reset = 1'b0;
    repeat (40) @(negedge clock);
    n_cmp++;
    if (pulses - p0 !== 0) begin n_err++; $display("FAIL rstdeb_pulses: got %0d expected 0", pulses - p0); end
  endtask

  task automatic test_pulse_width();
    n_cmp++;
    if (max_run !== 1) begin n_err++; $display("FAIL pulse_width: got %0d expected 1", max_run); end
    n_cmp++;
    if (pulses !== 7) begin n_err++; $display("FAIL total_pulses: got %0d expected 7", pulses); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; pulses = 0; run_len = 0; max_run = 0;
    reset = 1'b1;
    keys  = 16'h0000;
    test_reset();
    test_single_key();
    test_key_sequence();
    test_bounce();
    test_priority_hold();
    test_reset_mid_debounce();
    test_pulse_width();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart of the multiplexed seven-segment display path: scans a 4x4 matrix keypad by strobing columns active-low and reading rows active-low, the way the display path strobes digits. Debounces presses and emits one hex key code per press. Shifts each accepted code into a 16-bit register that can drive the display's `value` input directly.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven before the rows are sampled (minimum 2).
- `DEBOUNCE`, default 8: consecutive matching samples needed to accept a press or a release (minimum 1, maximum 255).

Ports:
- `clock`  in  1: system clock; the block has one clock.
- `reset`  in  1: synchronous, active-high reset.
- `row`  in  4: keypad row lines, active-low, asynchronous to `clock`.
- `col`  out  4: keypad column strobes, active-low, exactly one low at a time.
- `key`  out  4: code of the last accepted key.
- `key_valid`  out  1: one-cycle pulse when a new key is accepted.
- `key_held`  out  1: high while the accepted key is still pressed.
- `value`  out  16: shift register of the last four accepted keys, newest key in bits [3:0].

## Operation
- **Row synchronizer:** `row` passes through a 2-flop synchronizer; all decisions use the synchronized value `rs`.
- **Divider:** counts 0..SCAN_DIV-1 and wraps. The internal `tick` is high in the cycle where the divider equals SCAN_DIV-1. Rows are evaluated only on `tick`.
- **Column index:** `ci` (2 bits). `col = ~(4'b0001 << ci)`. `ci` advances (3 wraps to 0) only where stated below.
- **Row decode:** `pressed = (rs != 4'b1111)`. `ri` is the lowest-index row with `rs[i] == 0`, so lower rows have priority.
- **Key code:** `key = {ri, ci}`, i.e. row*4 + col.

State machine, with transitions evaluated on `tick` only:
- **SCAN**
  - If `pressed`: latch `ri` and `ci` as the candidate, set the counter to 1, and go to DEBOUNCE. If DEBOUNCE==1, accept immediately (see accept).
  - Otherwise advance `ci`.
- **DEBOUNCE** (`ci` frozen)
  - If `pressed` and `ri` equals the candidate row: increment the counter. When it reaches DEBOUNCE, accept.
  - Otherwise go to SCAN and advance `ci`. Nothing is output.
- **Accept** (one cycle of action, then HELD)
  - `key <= candidate`.
  - `value <= {value[11:0], candidate}`.
  - `key_valid` pulses for one cycle.
  - `key_held <= 1`, the release counter clears, and the state goes to HELD.
- **HELD** (`ci` frozen)
  - If `!pressed`: increment the release counter.
  - If `pressed` (any row): clear the release counter.
  - When the release counter reaches DEBOUNCE: `key_held <= 0`, advance `ci`, go to SCAN.

Boundary rules:
- A second key pressed while HELD does not produce a new code.
- A key in a different column is never seen while `ci` is frozen.

## Timing
- **Reset values:** `col=4'b1110` (ci=0), `key=0`, `key_valid=0`, `key_held=0`, `value=16'h0000`, state SCAN, divider 0, counters 0, synchronizer flops set to 1. Reset mid-debounce or while HELD aborts with no `key_valid` pulse.
- **Input latency:** a `row` change is visible in `rs` 2 cycles later. It must be stable before the `tick` cycle to be counted at that tick.
- **Accept latency:** `key`, `value`, `key_held` and `key_valid` update in the cycle after the DEBOUNCE-th consecutive matching tick. The minimum press-to-valid time is (DEBOUNCE-1)*SCAN_DIV cycles after the first detecting tick, plus 1.
- **Column change:** `col` changes in the cycle after the tick that advances `ci`.
- **Pulse width:** `key_valid` is high for exactly 1 cycle and never fires twice for one press.
- **Release latency:** `key_held` falls in the cycle after the DEBOUNCE-th consecutive released tick.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=3, and a bench keypad model that drives `row` low in the strobed column.

- **Reset:** assert `reset` for 2 cycles, release it and scan idle for 40 cycles -> `col` cycles 1110,1101,1011,0111 every 4 cycles; `key_valid` stays 0; `value=0`.
- **Single key:** hold row 2, col 1 -> exactly one `key_valid` pulse with `key=4'h9`, `value=16'h0009`, `key_held=1`. Release -> `key_held` falls 3 ticks later and scanning resumes.
- **Key sequence:** press and release codes 1,2,3,4,5 in order -> five pulses, final `value=16'h2345`, `key=5`.
- **Bounce rejection:** press row 0, col 3 for only 2 ticks, then bounce released -> no `key_valid`, `value` unchanged, scanning resumes at the next column.
- **Priority and hold:** hold rows 1 and 3 of col 2 for 50 ticks -> a single pulse with `key=4'h6`. Add row 0, col 2 while HELD -> no new pulse.
- **Reset mid-debounce:** assert `reset` after 2 matching ticks -> no pulse, all outputs return to their reset values, `col=4'b1110`.
